// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared types and defaults for the vdp VRAM write path
package vdp_pkg;

  localparam int VDP_DW         = 24;
  localparam int VDP_AW         = 16;
  localparam int VDP_VRAM_WORDS = 280 * 192;

  // Requester index doubles as the grant bit position
  typedef enum logic [1:0] {
    SRC_REN  = 2'd0,
    SRC_HOST = 2'd1,
    SRC_FILL = 2'd2
  } wr_src_t;

  typedef struct packed {
    logic [VDP_AW-1:0] adr;
    logic [VDP_DW-1:0] d;
  } vram_wr_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - three-way round-robin grant with registered priority pointer
module rr_arb3
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       adv,
  output logic [2:0] gnt
);

  logic [1:0] p_q;
  logic [1:0] p_d;

  // Search from the pointer upward (mod 3); first active request wins
  always_comb begin
    gnt = 3'b000;
    case (p_q)
      2'd0: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      default: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
    endcase
  end

  // Pointer moves to the requester just after the winner; holds when idle
  always_comb begin
    p_d = p_q;
    if (adv) begin
      case (gnt)
        3'b001:  p_d = 2'd1;
        3'b010:  p_d = 2'd2;
        3'b100:  p_d = 2'd0;
        default: p_d = p_q;
      endcase
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (reset) p_q <= 2'd0;
    else       p_q <= p_d;
  end

endmodule

// File: rtl/vram_wr_arb.sv
// rtl/vram_wr_arb.sv - VRAM write-port arbiter with fill engine and registered write outputs
module vram_wr_arb
  import vdp_pkg::*;
#(
  parameter int DW         = VDP_DW,
  parameter int AW         = VDP_AW,
  parameter int VRAM_WORDS = VDP_VRAM_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ren_valid,
  output logic          ren_ready,
  input  logic [AW-1:0] ren_adr,
  input  logic [DW-1:0] ren_d,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_d,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          oob,
  output logic          vram_we,
  output logic [AW-1:0] vram_wadr,
  output logic [DW-1:0] vram_d
);

  // One extra bit so a full 2^AW word count still compares correctly
  localparam logic [AW:0]   WORDS_X  = (AW+1)'(VRAM_WORDS);
  localparam logic [AW-1:0] LAST_ADR = AW'(VRAM_WORDS - 1);

  fill_state_t   fill_state_q;
  logic [AW-1:0] fill_cnt_q;
  logic [DW-1:0] fill_color_q;
  logic          fill_done_q;

  logic          vram_we_q;
  logic [AW-1:0] vram_wadr_q;
  logic [DW-1:0] vram_d_q;
  logic          oob_q;

  logic [2:0]    req;
  logic [2:0]    gnt;
  logic          any_gnt;
  logic          in_range;
  wr_src_t       src;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_d;

  assign fill_busy = (fill_state_q == FILL_RUN);
  assign req       = {fill_busy, host_valid, ren_valid};

  rr_arb3 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .adv   (any_gnt),
    .gnt   (gnt)
  );

  assign any_gnt    = |gnt;
  assign ren_ready  = gnt[0];
  assign host_ready = gnt[1];

  // Route the granted requester's address/data onto the write path
  always_comb begin
    src = SRC_REN;
    if (gnt[1])      src = SRC_HOST;
    else if (gnt[2]) src = SRC_FILL;
    case (src)
      SRC_HOST: begin
        sel_adr = host_adr;
        sel_d   = host_d;
      end
      SRC_FILL: begin
        sel_adr = fill_cnt_q;
        sel_d   = fill_color_q;
      end
      default: begin
        sel_adr = ren_adr;
        sel_d   = ren_d;
      end
    endcase
  end

  assign in_range = ({1'b0, sel_adr} < WORDS_X);

  // Register accepted writes; out-of-range ones are swallowed and flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_we_q   <= 1'b0;
      vram_wadr_q <= '0;
      vram_d_q    <= '0;
      oob_q       <= 1'b0;
    end else begin
      vram_we_q <= any_gnt & in_range;
      oob_q     <= any_gnt & ~in_range;
      if (any_gnt && in_range) begin
        vram_wadr_q <= sel_adr;
        vram_d_q    <= sel_d;
      end
    end
  end

  // Fill sequencer: walks every address once, then pulses done and idles
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_state_q <= FILL_IDLE;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (fill_state_q)
        FILL_IDLE: begin
          if (fill_start) begin
            fill_state_q <= FILL_RUN;
            fill_cnt_q   <= '0;
            fill_color_q <= fill_color;
          end
        end
        default: begin
          // A restart request here is deliberately ignored
          if (gnt[2]) begin
            if (fill_cnt_q == LAST_ADR) begin
              fill_state_q <= FILL_IDLE;
              fill_done_q  <= 1'b1;
            end else begin
              fill_cnt_q <= fill_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign fill_done = fill_done_q;
  assign oob       = oob_q;
  assign vram_we   = vram_we_q;
  assign vram_wadr = vram_wadr_q;
  assign vram_d    = vram_d_q;

endmodule
